// File: rtl/instr_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_ctrl
// Description : Fetch sequencer for a combinational instruction ROM. Owns the
//               program counter, registers each fetched byte into a one-entry
//               output slot offered to decode over valid/ready, and handles
//               branch redirects, halt requests, restart and PC wrap-around.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_ctrl #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 8,
  parameter bit WRAP_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              halt_req,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic [7:0]        issue_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] c_pc_max  = '1;
  localparam logic [7:0]        c_cnt_max = 8'hFF;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   w_pc_nxt;
  logic [DATA_W-1:0]   r_instr;
  logic [DATA_W-1:0]   w_instr_nxt;
  logic [ADDR_W-1:0]   r_instr_pc;
  logic [ADDR_W-1:0]   w_instr_pc_nxt;
  logic                r_valid;
  logic                w_valid_nxt;
  logic                r_halted;
  logic [7:0]          r_issue_cnt;
  logic                w_accept;
  logic                w_slot_free;

  assign w_accept    = r_valid && instr_ready;
  assign w_slot_free = !r_valid || instr_ready;

  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_valid;
  assign halted      = r_halted;
  assign issue_cnt   = r_issue_cnt;

  // Next-state and slot/PC update: halt beats redirect beats capture in RUN.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_instr_nxt    = r_instr;
    w_instr_pc_nxt = r_instr_pc;
    w_valid_nxt    = r_valid;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_valid_nxt = 1'b0;
        if (start)    w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (halt_req) begin
          // Pending slot is kept until decode takes it.
          w_state_nxt = S_HALT;
          if (w_accept) w_valid_nxt = 1'b0;
        end else if (redirect_valid) begin
          // Flush the slot; the cycle spent here is the branch bubble.
          w_pc_nxt    = redirect_addr;
          w_valid_nxt = 1'b0;
        end else if (w_slot_free) begin
          w_instr_nxt    = imem_data;
          w_instr_pc_nxt = r_pc;
          w_valid_nxt    = 1'b1;
          w_pc_nxt       = r_pc + 1'b1;
          if (!WRAP_EN && (r_pc == c_pc_max)) w_state_nxt = S_HALT;
        end
      end
      S_HALT: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_pc_nxt    = '0;
          w_valid_nxt = 1'b0;
        end else if (w_accept) begin
          w_valid_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, PC and output slot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pc       <= '0;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_valid    <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_instr    <= w_instr_nxt;
      r_instr_pc <= w_instr_pc_nxt;
      r_valid    <= w_valid_nxt;
      r_halted   <= (w_state_nxt == S_HALT);
    end
  end

  // Saturating count of instructions handed to decode, in any state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issue_cnt <= 8'd0;
    end else if (w_accept && (r_issue_cnt != c_cnt_max)) begin
      r_issue_cnt <= r_issue_cnt + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_ctrl
// Description : Scoreboard bench for instr_fetch_ctrl; one instance wraps the
//               PC, a second stops after the fetch at the top address.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_ctrl;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          halt_req = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_addr = '0;
  logic          instr_ready = 1'b0;

  logic [DW-1:0] rom [16];

  logic [AW-1:0] imem_addr   [2];
  logic [DW-1:0] imem_data   [2];
  logic [DW-1:0] instr       [2];
  logic [AW-1:0] instr_pc    [2];
  logic          instr_valid [2];
  logic [AW-1:0] pc          [2];
  logic          halted      [2];
  logic [7:0]    issue_cnt   [2];

  always #5 clk = ~clk;

  assign imem_data[0] = rom[imem_addr[0]];
  assign imem_data[1] = rom[imem_addr[1]];

  instr_fetch_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WRAP_EN(1'b1)) u_dut_wrap (
    .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .imem_addr(imem_addr[0]), .imem_data(imem_data[0]),
    .instr(instr[0]), .instr_pc(instr_pc[0]), .instr_valid(instr_valid[0]),
    .instr_ready(instr_ready), .pc(pc[0]), .halted(halted[0]),
    .issue_cnt(issue_cnt[0])
  );

  instr_fetch_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WRAP_EN(1'b0)) u_dut_nowrap (
    .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .imem_addr(imem_addr[1]), .imem_data(imem_data[1]),
    .instr(instr[1]), .instr_pc(instr_pc[1]), .instr_valid(instr_valid[1]),
    .instr_ready(instr_ready), .pc(pc[1]), .halted(halted[1]),
    .issue_cnt(issue_cnt[1])
  );

  // Reference model: architectural view of each instance after every edge.
  int          mst  [2];
  logic [3:0]  mpc  [2];
  bit          mval [2];
  logic [7:0]  minstr [2];
  logic [3:0]  mipc [2];
  int          mcnt [2];
  logic [11:0] sbq [$];
  logic [11:0] sb_exp;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mst[m] = M_IDLE; mpc[m] = '0; mval[m] = 1'b0;
      minstr[m] = '0; mipc[m] = '0; mcnt[m] = 0;
    end
    sbq.delete();
  endtask

  // Predict the effect of the next rising edge given the inputs now applied.
  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      bit acc;
      acc = mval[m] && instr_ready;
      if (acc && mcnt[m] < 255) mcnt[m]++;
      if (mst[m] == M_RUN) begin
        if (halt_req) begin
          mst[m] = M_HALT;
          if (acc) mval[m] = 1'b0;
        end else if (redirect_valid) begin
          if (m == 0 && mval[m] && !acc) void'(sbq.pop_back());
          mpc[m]  = redirect_addr;
          mval[m] = 1'b0;
        end else if (!mval[m] || instr_ready) begin
          minstr[m] = rom[mpc[m]];
          mipc[m]   = mpc[m];
          mval[m]   = 1'b1;
          if (m == 0) sbq.push_back({mpc[m], rom[mpc[m]]});
          if (m == 1 && mpc[m] == 4'd15) mst[m] = M_HALT;
          mpc[m] = mpc[m] + 4'd1;
        end
      end else if (mst[m] == M_HALT && start) begin
        if (m == 0 && mval[m] && !acc) void'(sbq.pop_back());
        mst[m]  = M_RUN;
        mpc[m]  = '0;
        mval[m] = 1'b0;
      end else begin
        if (acc) mval[m] = 1'b0;
        if (mst[m] == M_IDLE && start) mst[m] = M_RUN;
      end
    end
  endtask

  task automatic check_outputs();
    for (int m = 0; m < 2; m++) begin
      string s;
      s = (m == 0) ? "wrap" : "nowrap";
      chk({"pc_", s},     pc[m],          mpc[m]);
      chk({"valid_", s},  instr_valid[m], mval[m]);
      chk({"halted_", s}, halted[m],      (mst[m] == M_HALT));
      chk({"cnt_", s},    issue_cnt[m],   mcnt[m]);
      if (mval[m]) begin
        chk({"instr_", s},    instr[m],    minstr[m]);
        chk({"instr_pc_", s}, instr_pc[m], mipc[m]);
      end
    end
  endtask

  task automatic cyc(input bit s, input bit h, input bit r, input logic [3:0] ra, input bit rdy);
    @(negedge clk);
    check_outputs();
    start = s; halt_req = h; redirect_valid = r; redirect_addr = ra; instr_ready = rdy;
    model_step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    start = 0; halt_req = 0; redirect_valid = 0; redirect_addr = '0; instr_ready = 0;
    rst_n = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("rst_valid", instr_valid[m], 1'b0);
      chk("rst_pc",    pc[m],          4'd0);
      chk("rst_cnt",   issue_cnt[m],   8'd0);
      chk("rst_halt",  halted[m],      1'b0);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: every handshake on the wrapping instance must deliver the
  // oldest instruction still owed by the scoreboard.
  always @(negedge clk) begin
    #2;
    if (rst_n && instr_valid[0] && instr_ready) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got instr %0h pc %0h expected none", instr[0], instr_pc[0]);
      end else begin
        sb_exp = sbq.pop_front();
        chk("sb_instr", instr[0],    sb_exp[7:0]);
        chk("sb_pc",    instr_pc[0], sb_exp[11:8]);
      end
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
    rom[0] = 8'hA6; rom[1] = 8'hAF; rom[2] = 8'hB4; rom[3] = 8'hBD;
    model_reset();
    do_reset();
    cyc(0, 1, 1, 4'd5, 1);               // ignored in IDLE
    // sequential fetch, then backpressure while AF is in the slot
    cyc(1, 0, 0, 4'd0, 1);
    cyc(0, 0, 0, 4'd0, 1);
    cyc(0, 0, 0, 4'd0, 1);
    repeat (3) cyc(0, 0, 0, 4'd0, 0);
    repeat (10) cyc(0, 0, 0, 4'd0, 1);   // slot now at pc 11
    cyc(0, 0, 1, 4'd3, 1);               // redirect to 3
    repeat (3) cyc(0, 0, 0, 4'd0, 1);
    cyc(0, 1, 1, 4'd9, 0);               // halt wins over redirect
    cyc(0, 0, 1, 4'd9, 0);
    cyc(0, 0, 0, 4'd0, 1);               // drain held slot in HALT
    cyc(1, 0, 0, 4'd0, 1);               // restart from 0
    repeat (20) cyc(0, 0, 0, 4'd0, 1);   // wrap vs stop-at-top
    cyc(0, 0, 0, 4'd0, 1);
    do_reset();                          // async reset mid-stream
    cyc(1, 0, 0, 4'd0, 1);
    repeat (3) cyc(0, 0, 0, 4'd0, 1);
    do_reset();
    // long streaming run to reach counter saturation
    repeat (300) cyc(1, 0, 0, 4'd0, 1);
    // randomized traffic
    repeat (400) begin
      cyc($urandom_range(0, 99) < 8, $urandom_range(0, 99) < 4,
          $urandom_range(0, 99) < 12, 4'($urandom), $urandom_range(0, 99) < 70);
      if ($urandom_range(0, 199) == 0) do_reset();
    end
    cyc(0, 0, 0, 4'd0, 0);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
